// File: rtl/nor3_arc_sequencer_if.sv
// Bus between the characterisation controller, the sequencer and the cell under test.
interface nor3_arc_sequencer_if #(
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic             qn_sense;
  logic             in1;
  logic             in2;
  logic             in3;
  logic [4:0]       arc_id;
  logic             arc_stb;
  logic             busy;
  logic             done;
  logic             err_stb;
  logic [CNT_W-1:0] err_cnt;

  // Controller / cell side.
  modport master (
    output start, qn_sense,
    input  in1, in2, in3, arc_id, arc_stb, busy, done, err_stb, err_cnt
  );

  // Sequencer side.
  modport slave (
    input  start, qn_sense,
    output in1, in2, in3, arc_id, arc_stb, busy, done, err_stb, err_cnt
  );
endinterface

// File: rtl/nor3_arc_sequencer.sv
// Walks a 3-input NOR cell through all 24 single-input toggle arcs, holding each
// vector for DWELL cycles and counting QN mismatches against the NOR truth table.
module nor3_arc_sequencer #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic                 CLK,
  input logic                 RST,
  nor3_arc_sequencer_if.slave bus
);

  localparam int unsigned PH_W    = $clog2(DWELL);
  localparam int unsigned ID_W    = 5;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DWELL - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_RISE  = 2'd2,
    S_FALL  = 2'd3
  } state_e;

  state_e           state_q,   state_d;
  logic [PH_W-1:0]  phase_q,   phase_d;
  logic [1:0]       pin_q,     pin_d;
  logic [1:0]       side_q,    side_d;
  logic [2:0]       in_q,      in_d;
  logic [ID_W-1:0]  arc_id_q,  arc_id_d;
  logic             arc_stb_q, arc_stb_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic             err_stb_q, err_stb_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic phase_last;
  logic last_pair;
  logic active;

  assign phase_last = (phase_q == PH_LAST);
  assign last_pair  = (pin_q == 2'd2) && (side_q == 2'd3);

  // State register and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      pin_q     <= '0;
      side_q    <= '0;
      in_q      <= '0;
      arc_id_q  <= '0;
      arc_stb_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_stb_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      pin_q     <= pin_d;
      side_q    <= side_d;
      in_q      <= in_d;
      arc_id_q  <= arc_id_d;
      arc_stb_q <= arc_stb_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_stb_q <= err_stb_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Next-state sequencing, QN check and next output values.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    pin_d     = pin_q;
    side_d    = side_q;
    done_d    = 1'b0;
    err_stb_d = 1'b0;
    err_cnt_d = err_cnt_q;
    active    = 1'b0;
    in_d      = '0;
    arc_id_d  = '0;
    arc_stb_d = 1'b0;
    busy_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_SETUP;
          phase_d   = '0;
          pin_d     = '0;
          side_d    = '0;
          err_cnt_d = '0;
        end
      end
      S_SETUP: begin
        phase_d = phase_q + PH_W'(1);
        if (phase_last) begin
          state_d = S_RISE;
          phase_d = '0;
        end
      end
      S_RISE: begin
        phase_d = phase_q + PH_W'(1);
        if (phase_last) begin
          state_d = S_FALL;
          phase_d = '0;
        end
      end
      S_FALL: begin
        phase_d = phase_q + PH_W'(1);
        if (phase_last) begin
          phase_d = '0;
          if (last_pair) begin
            state_d = S_IDLE;
            pin_d   = '0;
            side_d  = '0;
            done_d  = 1'b1;
          end else begin
            state_d = S_SETUP;
            if (side_q == 2'd3) begin
              side_d = '0;
              pin_d  = pin_q + 2'd1;
            end else begin
              side_d = side_q + 2'd1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Compare QN against the NOR of the vector being driven, at the end of each check dwell.
    if (((state_q == S_RISE) || (state_q == S_FALL)) && phase_last &&
        (bus.qn_sense != ~|in_q)) begin
      err_stb_d = 1'b1;
      if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end

    // Drive vector: active pin high only in RISE, side[0] on lower other pin, side[1] on higher.
    active = (state_d == S_RISE);
    if (state_d != S_IDLE) begin
      case (pin_d)
        2'd0:    in_d = {side_d[1], side_d[0], active};
        2'd1:    in_d = {side_d[1], active, side_d[0]};
        default: in_d = {active, side_d[1], side_d[0]};
      endcase
      arc_id_d = {pin_d, side_d, (state_d == S_FALL)};
    end
    arc_stb_d = (state_d != state_q) && ((state_d == S_RISE) || (state_d == S_FALL));
    busy_d    = (state_d != S_IDLE);
  end

  assign bus.in1     = in_q[0];
  assign bus.in2     = in_q[1];
  assign bus.in3     = in_q[2];
  assign bus.arc_id  = arc_id_q;
  assign bus.arc_stb = arc_stb_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err_stb = err_stb_q;
  assign bus.err_cnt = err_cnt_q;

endmodule
